// File: rtl/gpr_writeback_queue.sv
// Write-back queue owning the register file's single write port: merges ALU and
// load-unit writes into an in-order queue, drains one per cycle, and serves bypass reads.
module gpr_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    // Handshake: a request transfers on a rising edge where valid and ready are both
    // high. Readies depend only on registered state (plus alu_valid for ld_ready),
    // never on the requester's own valid, and a same-cycle drain does not free space.
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          gpr_we,
    output logic [AW-1:0] gpr_addr,
    output logic [DW-1:0] gpr_wdata,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          byp_hit_a,
    output logic [DW-1:0] byp_data_a,
    output logic          byp_hit_b,
    output logic [DW-1:0] byp_data_b,
    output logic          busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [CW-1:0] count_next;
    logic          alu_acc;
    logic          ld_acc;
    logic          alu_enq;
    logic          ld_enq;
    logic          pop;
    logic [PW-1:0] ld_slot;

    assign free      = FULL - count;
    assign alu_ready = (free >= CW'(1));
    assign ld_ready  = alu_valid ? (free >= CW'(2)) : (free >= CW'(1));

    assign alu_acc = alu_valid & alu_ready;
    assign ld_acc  = ld_valid & ld_ready;
    // Writes to register 0 complete the handshake but are dropped here.
    assign alu_enq = alu_acc & (alu_addr != '0);
    assign ld_enq  = ld_acc & (ld_addr != '0);
    assign pop     = (count != '0);

    // The load entry lands behind the ALU entry when both enqueue together.
    assign ld_slot    = alu_enq ? (wr_ptr + PW'(1)) : wr_ptr;
    assign count_next = count + CW'(alu_enq) + CW'(ld_enq) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            wr_ptr <= wr_ptr + PW'(alu_enq) + PW'(ld_enq);
            count  <= count_next;
        end
    end

    // Payload storage needs no reset; only slots covered by count are ever observed.
    always_ff @(posedge clk) begin
        if (alu_enq) begin
            mem[wr_ptr] <= '{addr: alu_addr, data: alu_data};
        end
        if (ld_enq) begin
            mem[ld_slot] <= '{addr: ld_addr, data: ld_data};
        end
    end

    assign gpr_we    = pop;
    assign gpr_addr  = mem[rd_ptr].addr;
    assign gpr_wdata = mem[rd_ptr].data;
    assign busy      = pop;

    // age_idx[i] is the slot of the i-th oldest entry; live[i] marks it as queued.
    logic [PW-1:0]    age_idx [DEPTH];
    logic [DEPTH-1:0] live;

    for (genvar i = 0; i < DEPTH; i++) begin : g_age
        assign age_idx[i] = rd_ptr + PW'(i);
        assign live[i]    = (CW'(i) < count);
    end

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        byp_hit_a  = 1'b0;
        byp_data_a = '0;
        byp_hit_b  = 1'b0;
        byp_data_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (rd_addr_a != '0) && (mem[age_idx[i]].addr == rd_addr_a)) begin
                byp_hit_a  = 1'b1;
                byp_data_a = mem[age_idx[i]].data;
            end
            if (live[i] && (rd_addr_b != '0) && (mem[age_idx[i]].addr == rd_addr_b)) begin
                byp_hit_b  = 1'b1;
                byp_data_b = mem[age_idx[i]].data;
            end
        end
    end

endmodule

// File: tb/tb_gpr_writeback_queue.sv
// Bench for gpr_writeback_queue: directed scenarios plus random traffic, all checked
// against a queue-based model of the write-back rules.
module tb_gpr_writeback_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk;
    logic          rst_n;
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          gpr_we;
    logic [AW-1:0] gpr_addr;
    logic [DW-1:0] gpr_wdata;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          byp_hit_a;
    logic [DW-1:0] byp_data_a;
    logic          byp_hit_b;
    logic [DW-1:0] byp_data_b;
    logic          busy;

    gpr_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .gpr_we     (gpr_we),
        .gpr_addr   (gpr_addr),
        .gpr_wdata  (gpr_wdata),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .byp_hit_a  (byp_hit_a),
        .byp_data_a (byp_data_a),
        .byp_hit_b  (byp_hit_b),
        .byp_data_b (byp_data_b),
        .busy       (busy)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    // Scoreboard: queued writes in FIFO order, plus a log of writes seen at the port.
    entry_t        model_q[$];
    entry_t        wr_log[$];
    int            tests = 0;
    int            fails = 0;

    // Snapshot of the most recent cycle's outputs for directed checks.
    logic          s_alu_ready, s_ld_ready, s_gpr_we, s_busy, s_hit_a, s_hit_b;
    logic [AW-1:0] s_gpr_addr;
    logic [DW-1:0] s_gpr_wdata, s_data_a, s_data_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_lookup(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] dat);
        hit = 1'b0;
        dat = '0;
        if (ra != '0) begin
            foreach (model_q[k]) begin
                if (model_q[k].addr == ra) begin
                    hit = 1'b1;
                    dat = model_q[k].data;
                end
            end
        end
    endtask

    // Driver: one clock cycle. Inputs applied after the falling edge, outputs checked
    // 1 time unit later, model advanced at the rising edge.
    task automatic cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        int            cnt;
        logic          e_ar, e_lr, e_hit_a, e_hit_b;
        logic [DW-1:0] e_dat_a, e_dat_b;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid  = lv; ld_addr  = la; ld_data  = ld;
        rd_addr_a = ra; rd_addr_b = rb;
        #1;
        cnt  = model_q.size();
        e_ar = (cnt <= DEPTH - 1);
        e_lr = av ? (cnt <= DEPTH - 2) : (cnt <= DEPTH - 1);
        s_alu_ready = alu_ready; s_ld_ready = ld_ready; s_gpr_we = gpr_we; s_busy = busy;
        s_gpr_addr = gpr_addr; s_gpr_wdata = gpr_wdata;
        s_hit_a = byp_hit_a; s_data_a = byp_data_a; s_hit_b = byp_hit_b; s_data_b = byp_data_b;
        check("alu_ready", 64'(alu_ready), 64'(e_ar));
        check("ld_ready", 64'(ld_ready), 64'(e_lr));
        check("gpr_we", 64'(gpr_we), 64'(cnt != 0));
        check("busy", 64'(busy), 64'(cnt != 0));
        if (cnt != 0) begin
            check("gpr_addr", 64'(gpr_addr), 64'(model_q[0].addr));
            check("gpr_wdata", 64'(gpr_wdata), 64'(model_q[0].data));
            wr_log.push_back('{addr: gpr_addr, data: gpr_wdata});
        end
        model_lookup(ra, e_hit_a, e_dat_a);
        model_lookup(rb, e_hit_b, e_dat_b);
        check("byp_hit_a", 64'(byp_hit_a), 64'(e_hit_a));
        check("byp_hit_b", 64'(byp_hit_b), 64'(e_hit_b));
        if (e_hit_a || ra == '0) check("byp_data_a", 64'(byp_data_a), 64'(e_dat_a));
        if (e_hit_b || rb == '0) check("byp_data_b", 64'(byp_data_b), 64'(e_dat_b));
        @(posedge clk);
        if (cnt != 0) void'(model_q.pop_front());
        if (av && e_ar && aa != '0) model_q.push_back('{addr: aa, data: ad});
        if (lv && e_lr && la != '0) model_q.push_back('{addr: la, data: ld});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        #1;
        check("reset_gpr_we", 64'(gpr_we), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_hit_a", 64'(byp_hit_a), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single write: visible on the port the cycle after acceptance, then idle.
        cycle(1'b1, 5'd5, 32'hAA, 1'b0, '0, '0, '0, '0);
        check("single_acc_ready", 64'(s_alu_ready), 64'(1));
        idle(1);
        check("single_we", 64'(s_gpr_we), 64'(1));
        check("single_addr", 64'(s_gpr_addr), 64'(5));
        check("single_data", 64'(s_gpr_wdata), 64'(32'hAA));
        idle(1);
        check("single_we_after", 64'(s_gpr_we), 64'(0));

        // Dual accept: ALU entry is older than the load entry.
        wr_log.delete();
        cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, '0, '0);
        check("dual_alu_ready", 64'(s_alu_ready), 64'(1));
        check("dual_ld_ready", 64'(s_ld_ready), 64'(1));
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd3, '0);
        check("dual_byp_data", 64'(s_data_a), 64'(32'h22));
        idle(2);
        check("dual_nwrites", 64'(wr_log.size()), 64'(2));
        if (wr_log.size() == 2) begin
            check("dual_first", 64'(wr_log[0].data), 64'(32'h11));
            check("dual_second", 64'(wr_log[1].data), 64'(32'h22));
        end

        // Backpressure: two dual cycles bring the queue to 3 entries, leaving one slot.
        cycle(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h102, '0, '0);
        cycle(1'b1, 5'd3, 32'h103, 1'b1, 5'd4, 32'h104, '0, '0);
        cycle(1'b1, 5'd5, 32'h105, 1'b1, 5'd6, 32'h106, '0, '0);
        check("bp_alu_ready", 64'(s_alu_ready), 64'(1));
        check("bp_ld_ready", 64'(s_ld_ready), 64'(0));
        idle(5);

        // Wrap-around: ten back-to-back single requests drain in order.
        wr_log.delete();
        for (int i = 1; i <= 10; i++) cycle(1'b1, AW'(i), DW'(i * 16), 1'b0, '0, '0, '0, '0);
        idle(2);
        check("wrap_nwrites", 64'(wr_log.size()), 64'(10));
        foreach (wr_log[k]) check("wrap_order", 64'(wr_log[k].addr), 64'(k + 1));

        // Register 0: handshake completes, nothing queued.
        cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hDEAD, '0, 5'd0);
        check("r0_ld_ready", 64'(s_ld_ready), 64'(1));
        check("r0_hit_b", 64'(s_hit_b), 64'(0));
        idle(1);
        check("r0_no_write", 64'(s_gpr_we), 64'(0));
        check("r0_not_busy", 64'(s_busy), 64'(0));

        // Bypass youngest: build (7,1),(9,2),(7,3) behind a throw-away head.
        cycle(1'b1, 5'd2, 32'h50, 1'b1, 5'd7, 32'h1, '0, '0);
        cycle(1'b1, 5'd9, 32'h2, 1'b1, 5'd7, 32'h3, '0, '0);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd7, '0);
        check("young_hit", 64'(s_hit_a), 64'(1));
        check("young_data", 64'(s_data_a), 64'(32'h3));
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd7, '0);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd7, '0);
        check("young_head_hit", 64'(s_hit_a), 64'(1));
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd7, '0);
        check("young_gone", 64'(s_hit_a), 64'(0));

        // Reset mid-stream with 3 queued entries.
        cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, '0, '0);
        cycle(1'b1, 5'd4, 32'hA4, 1'b1, 5'd6, 32'hA6, '0, '0);
        check("pre_rst_busy", 64'(model_q.size()), 64'(3));
        alu_valid = 1'b0; ld_valid = 1'b0; rd_addr_a = 5'd4;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gpr_we", 64'(gpr_we), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_hit_a", 64'(byp_hit_a), 64'(0));
        model_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_log.delete();
        idle(4);
        check("post_rst_no_writes", 64'(wr_log.size()), 64'(0));

        // Random traffic over a small address range to exercise bypass matches.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpr_writeback_queue.md
Name: gpr_writeback_queue

Overview:
- Producer-side counterpart of the general-purpose register file: it owns the file's single write port (write enable, write address, write data).
- Accepts register write requests from the ALU and the load unit, holds them in an in-order queue, and drains one write per cycle into the register file.
- Provides bypass lookups on read ports A and B, so decode sees values that are queued but not yet written.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
AW, 5, register address width
DW, 32, register data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU write request
alu_addr  in  AW  ALU destination register
alu_data  in  DW  ALU result
alu_ready  out  1  ALU request accepted this cycle when high with alu_valid
ld_valid  in  1  load-unit write request
ld_addr  in  AW  load destination register
ld_data  in  DW  load data
ld_ready  out  1  load request accepted this cycle when high with ld_valid
gpr_we  out  1  register-file write enable
gpr_addr  out  AW  register-file write address
gpr_wdata  out  DW  register-file write data
rd_addr_a  in  AW  register-file read address A (from decode)
rd_addr_b  in  AW  register-file read address B
byp_hit_a  out  1  queued write pending for rd_addr_a
byp_data_a  out  DW  newest queued data for rd_addr_a
byp_hit_b  out  1  as A, for rd_addr_b
byp_data_b  out  DW  as A, for rd_addr_b
busy  out  1  queue non-empty

Behaviour:
- State:
  - DEPTH-entry circular buffer of {addr, data}.
  - Read pointer and write pointer, each log2(DEPTH) bits; they wrap modulo DEPTH.
  - Registered count, 0..DEPTH.
- Reset (rst_n low, asynchronous): pointers=0, count=0, so gpr_we=0, busy=0, byp_hit_a/b=0.
  - gpr_addr/gpr_wdata are don't-care while gpr_we=0.
  - Reset mid-operation discards all queued writes; none reaches the register file.
- free = DEPTH - count, from the registered count only. A pop in the same cycle does not create space.
- Ready rules:
  - alu_ready = (free>=1).
  - ld_ready = alu_valid ? (free>=2) : (free>=1).
  - Each ready is valid even when its own valid is low.
- Accept = valid & ready.
- Ordering:
  - When both are accepted in one cycle, the ALU entry is enqueued first (older), then the load entry.
  - Across cycles, order is strict FIFO.
- Register 0:
  - A request with addr==0 is accepted under the same ready rules but is not enqueued; it consumes no slot.
  - Register 0 never appears on gpr_addr with gpr_we=1.
- Drain: gpr_we = (count!=0); gpr_addr/gpr_wdata = head entry, combinational from state.
  - Head pops at the rising edge whenever gpr_we=1; the register file captures it on that edge.
  - Drain rate is 1 per cycle and never stalls.
- count_next = count + enqueued(0..2) - popped(0..1); count never exceeds DEPTH.
- Latency: a request accepted in cycle N into an empty queue gives gpr_we=1 in cycle N+1 and is written at the end of N+1.
- Bypass (combinational):
  - byp_hit_x=1 if any valid queued entry, including the head being drained this cycle, has addr==rd_addr_x and rd_addr_x!=0.
  - byp_data_x = data of the youngest matching entry.
  - Requests presented in the current cycle are not visible to bypass.
  - rd_addr_x==0 gives hit=0 and data=0.
- busy = (count!=0).

Test Plan:
- Reset/idle: rst_n=0 mid-stream with 3 entries queued -> immediately gpr_we=0, busy=0, byp_hit_a=0; after release, no writes emerge.
- Single write: empty queue; cycle N alu_valid, addr=5, data=0x0000_00AA -> cycle N+1 gpr_we=1, gpr_addr=5, gpr_wdata=0xAA; cycle N+2 gpr_we=0.
- Dual accept order: empty queue; ALU (3, 0x11) and load (3, 0x22) in the same cycle -> both ready=1.
  - Next cycle: byp_data_a=0x22 for rd_addr_a=3.
  - Writes emerge as 0x11 then 0x22 on consecutive cycles.
- Backpressure: fill with count=3, DEPTH=4, both valid -> alu_ready=1, ld_ready=0; only ALU enqueued.
  - At count=4 -> both ready=0.
  - Wrap-around: 10 back-to-back single requests (addrs 1..10) drain in order 1..10.
- Register 0: ld_valid, addr=0, data=0xDEAD -> ld_ready=1, count unchanged, no gpr_we; rd_addr_b=0 -> byp_hit_b=0.
- Bypass youngest: queue holds (7, 0x1), (9, 0x2), (7, 0x3), rd_addr_a=7 -> byp_hit_a=1, byp_data_a=0x3.
  - After the two 7-entries drain -> byp_hit_a=0.
